// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: WIDTH-bit add done chunk by chunk on one shared CHUNK-bit adder
//
// Iterates N = WIDTH/CHUNK chunks LSB-first. The carry between chunks is
// registered. Valid/ready handshakes sit on both the operand and result sides.
// FSM: IDLE -> RUN (N cycles) -> DONE -> IDLE.
//
// Ports:
//   clk       in   clock; every state update is on the rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   operand request valid
//   in_ready  out  operands accepted (high only in IDLE)
//   a, b      in   WIDTH-bit operands, sampled on acceptance
//   cin       in   carry into chunk 0, sampled on acceptance
//   sub       in   (ADDER_SEQ_SUB_EN only) 1 = compute a - b, cout=1 means no borrow
//   out_valid out  result valid (high only in DONE)
//   out_ready in   consumer takes the result
//   sum       out  WIDTH-bit result, held while out_valid=1
//   cout      out  carry out of the MSB chunk
//   busy      out  high in RUN or DONE
//
// Optional feature macro: ADDER_SEQ_SUB_EN (adds the sub port and subtraction).

module adder #(
  parameter int BIT_COUNT = 8
) (
  input  logic [BIT_COUNT-1:0] a,
  input  logic [BIT_COUNT-1:0] b,
  input  logic                 cin,
  output logic [BIT_COUNT-1:0] sum,
  output logic                 cout
);
  // One extra bit holds the carry-out.
  logic [BIT_COUNT:0] r;
  assign r = {1'b0, a} + {1'b0, b} + {{BIT_COUNT{1'b0}}, cin};
  assign {cout, sum} = r;
endmodule

module adder_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, b_in, sum_nx;
  logic             cin_q, cin_in, carry, ci, c_c, last;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] s_c;

`ifdef ADDER_SEQ_SUB_EN
  // Inverting all of b up front equals inverting each chunk as it is used.
  assign b_in   = sub ? ~b : b;
  assign cin_in = sub | cin;
`else
  assign b_in   = b;
  assign cin_in = cin;
`endif

  assign last = idx == IW'(N - 1);
  assign ci   = (idx == '0) ? cin_q : carry;

  // Operands shift right each RUN cycle, so the current chunk is always the LSBs.
  adder #(.BIT_COUNT(CHUNK)) u_adder (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .cin  (ci),
    .sum  (s_c),
    .cout (c_c)
  );

  // The result also shifts in from the top; after N cycles every chunk is in place.
  if (N == 1) begin : g_one
    assign sum_nx = s_c;
  end else begin : g_many
    assign sum_nx = {s_c, sum[WIDTH-1:CHUNK]};
  end

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;

  always_comb begin
    state_nx = state;
    if (state == IDLE && in_valid) state_nx = RUN;
    if (state == RUN && last) state_nx = DONE;
    if (state == DONE && out_ready) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_q   <= a;
      b_q   <= b_in;
      cin_q <= cin_in;
      carry <= 1'b0;
      idx   <= '0;
    end else if (state == RUN) begin
      a_q   <= a_q >> CHUNK;
      b_q   <= b_q >> CHUNK;
      sum   <= sum_nx;
      carry <= c_c;
      idx   <= idx + 1'b1;
      if (last) cout <= c_c;
    end
  end
endmodule
